// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command parser.
// Contents: command codes (first byte of a frame), register-file addresses that
// receive the ALU operands, and the parser state encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;  // write: addr, data
    localparam logic [7:0] CMD_RD      = 8'hBB;  // read: addr
    localparam logic [7:0] CMD_ALU     = 8'hCC;  // ALU with operands: opA, opB, fun
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU without operands: fun

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_WAIT_RSP
    } state_t;

endpackage

// File: rtl/sys_ctrl_rx_if.sv
// Received-byte stream from the UART receiver into the command parser.
// Signals: rx_data (received byte), rx_valid (one-cycle pulse per frame),
// parity_error / stop_error (qualify the current rx_valid).
// Modports: master = UART receiver side, slave = parser side.
interface sys_ctrl_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              parity_error;
    logic              stop_error;

    modport master (output rx_data, rx_valid, parity_error, stop_error);
    modport slave  (input  rx_data, rx_valid, parity_error, stop_error);
endinterface

// File: rtl/sys_ctrl_rx.sv
// Command parser downstream of the UART receiver. Decodes multi-byte frames
// into single-cycle register write/read strobes and ALU execute strobes.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   rx             - received byte stream (sys_ctrl_rx_if.slave)
//   rsp_ready      - response path can accept a read or ALU result
//   rf_wr_en/rf_rd_en/rf_addr/rf_wr_data - register-file request
//   alu_en/alu_fun - ALU execute strobe and function
//   busy           - a frame is in progress or a request is pending
//   cmd_err        - pulse on an aborted or illegal frame
//   overrun        - pulse when a byte is dropped while waiting on rsp_ready
// Optional: define SYS_CTRL_RX_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYC cycles without a received byte.
module sys_ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned FUN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 2048
) (
    input  logic                clk,
    input  logic                rst,
    sys_ctrl_rx_if.slave        rx,
    input  logic                rsp_ready,
    output logic                rf_wr_en,
    output logic                rf_rd_en,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic                alu_en,
    output logic [FUN_W-1:0]    alu_fun,
    output logic                busy,
    output logic                cmd_err,
    output logic                overrun
);

    state_t            state, state_n;
    logic [DATA_W-1:0] rx_byte;
    logic              good, bad, addr_ok, timeout_hit;

    // Pending request captured before the response path is ready.
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [FUN_W-1:0]  fun_q, fun_n;
    logic              pend_alu, pend_alu_n;

    logic              rf_wr_en_n, rf_rd_en_n, alu_en_n, cmd_err_n, overrun_n;
    logic [ADDR_W-1:0] rf_addr_n;
    logic [DATA_W-1:0] rf_wr_data_n;
    logic [FUN_W-1:0]  alu_fun_n;

    assign rx_byte = rx.rx_data;
    assign good    = rx.rx_valid & ~rx.parity_error & ~rx.stop_error;
    assign bad     = rx.rx_valid & (rx.parity_error | rx.stop_error);
    assign addr_ok = (rx_byte[DATA_W-1:ADDR_W] == '0);
    assign busy    = (state != ST_IDLE);

`ifdef SYS_CTRL_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] idle_cnt;
    logic            timed;

    // WAIT_RSP and IDLE are not subject to the inter-byte timeout.
    assign timed       = (state != ST_IDLE) && (state != ST_WAIT_RSP);
    assign timeout_hit = timed && !rx.rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || rx.rx_valid || !timed) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        fun_n        = fun_q;
        pend_alu_n   = pend_alu;
        rf_wr_en_n   = 1'b0;
        rf_rd_en_n   = 1'b0;
        alu_en_n     = 1'b0;
        cmd_err_n    = 1'b0;
        overrun_n    = 1'b0;
        rf_addr_n    = rf_addr;
        rf_wr_data_n = rf_wr_data;
        alu_fun_n    = alu_fun;

        if (state == ST_WAIT_RSP) begin
            // Every byte arriving here is dropped, including one on the exit cycle.
            overrun_n = rx.rx_valid;
            if (rsp_ready) begin
                state_n = ST_IDLE;
                if (pend_alu) begin
                    alu_en_n  = 1'b1;
                    alu_fun_n = fun_q;
                end else begin
                    rf_rd_en_n = 1'b1;
                    rf_addr_n  = addr_q;
                end
            end
        end else if (bad) begin
            cmd_err_n = 1'b1;
            state_n   = ST_IDLE;
        end else if (good) begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_byte == DATA_W'(CMD_WR))           state_n = ST_WR_ADDR;
                    else if (rx_byte == DATA_W'(CMD_RD))      state_n = ST_RD_ADDR;
                    else if (rx_byte == DATA_W'(CMD_ALU))     state_n = ST_ALU_A;
                    else if (rx_byte == DATA_W'(CMD_ALU_NOP)) state_n = ST_ALU_FUN;
                    else                                      cmd_err_n = 1'b1;
                end
                ST_WR_ADDR, ST_RD_ADDR: begin
                    if (!addr_ok) begin
                        cmd_err_n = 1'b1;
                        state_n   = ST_IDLE;
                    end else if (state == ST_WR_ADDR) begin
                        addr_n  = rx_byte[ADDR_W-1:0];
                        state_n = ST_WR_DATA;
                    end else if (rsp_ready) begin
                        rf_rd_en_n = 1'b1;
                        rf_addr_n  = rx_byte[ADDR_W-1:0];
                        state_n    = ST_IDLE;
                    end else begin
                        addr_n     = rx_byte[ADDR_W-1:0];
                        pend_alu_n = 1'b0;
                        state_n    = ST_WAIT_RSP;
                    end
                end
                ST_WR_DATA: begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = addr_q;
                    rf_wr_data_n = rx_byte;
                    state_n      = ST_IDLE;
                end
                ST_ALU_A, ST_ALU_B: begin
                    rf_wr_en_n   = 1'b1;
                    rf_addr_n    = (state == ST_ALU_A) ? ADDR_W'(OPA_ADDR) : ADDR_W'(OPB_ADDR);
                    rf_wr_data_n = rx_byte;
                    state_n      = (state == ST_ALU_A) ? ST_ALU_B : ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    if (rsp_ready) begin
                        alu_en_n  = 1'b1;
                        alu_fun_n = rx_byte[FUN_W-1:0];
                        state_n   = ST_IDLE;
                    end else begin
                        fun_n      = rx_byte[FUN_W-1:0];
                        pend_alu_n = 1'b1;
                        state_n    = ST_WAIT_RSP;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            cmd_err_n = 1'b1;
            state_n   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            fun_q      <= '0;
            pend_alu   <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            cmd_err    <= 1'b0;
            overrun    <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_fun    <= '0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            fun_q      <= fun_n;
            pend_alu   <= pend_alu_n;
            rf_wr_en   <= rf_wr_en_n;
            rf_rd_en   <= rf_rd_en_n;
            alu_en     <= alu_en_n;
            cmd_err    <= cmd_err_n;
            overrun    <= overrun_n;
            rf_addr    <= rf_addr_n;
            rf_wr_data <= rf_wr_data_n;
            alu_fun    <= alu_fun_n;
        end
    end

endmodule
